// File: rtl/seg_pkg.sv
// Shared segment-pattern constants and decode helper for the seven-segment scan decoder.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;

    // Returns {illegal, digit}; unknown patterns report illegal with digit 0.
    function automatic logic [4:0] seg_to_bcd(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            SEG_0:   res = {1'b0, 4'd0};
            SEG_1:   res = {1'b0, 4'd1};
            SEG_2:   res = {1'b0, 4'd2};
            SEG_3:   res = {1'b0, 4'd3};
            SEG_4:   res = {1'b0, 4'd4};
            SEG_5:   res = {1'b0, 4'd5};
            SEG_6:   res = {1'b0, 4'd6};
            SEG_7:   res = {1'b0, 4'd7};
            SEG_8:   res = {1'b0, 4'd8};
            SEG_9:   res = {1'b0, 4'd9};
            default: res = {1'b1, 4'd0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_stable_filter.sv
// Stability filter: registers {AN,DISP}, counts identical samples and strobes once per stable run.
module seg_stable_filter
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] an_i,
    input  logic [6:0] disp_i,
    output logic       accept_o,
    output logic [3:0] an_o,
    output logic [6:0] disp_o
);

    localparam int              RUN_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(STABLE_CYCLES - 1);

    logic [10:0]      sample_q, sample_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             accept_q, accept_d;
    logic             same_s;
    logic             selected_s;

    // Run counter saturates at the threshold, so the pre-threshold value is seen once per run.
    always_comb begin
        sample_d   = {an_i, disp_i};
        same_s     = ({an_i, disp_i} == sample_q);
        selected_s = (an_i == AN_ONES) || (an_i == AN_TENS);
        run_d      = run_q;
        if (!same_s) begin
            run_d = {RUN_W{1'b0}};
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
        end else begin
            run_d = run_q;
        end
        accept_d = same_s && selected_s && (run_q == RUN_PRE);
    end

    // Sample register, run counter and accept strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sample_q <= 11'd0;
            run_q    <= {RUN_W{1'b0}};
            accept_q <= 1'b0;
        end else begin
            sample_q <= sample_d;
            run_q    <= run_d;
            accept_q <= accept_d;
        end
    end

    assign accept_o = accept_q;
    assign an_o     = sample_q[10:7];
    assign disp_o   = sample_q[6:0];

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the displayed BCD pair from scanned anode/segment lines.
// Optional build macro SEG_SCAN_MOD60_CHECK_EN rejects tens digits above 5.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT       = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] AN,
    input  logic [6:0] DISP,
    output logic [3:0] ONES,
    output logic [3:0] TENS,
    output logic       VALID,
    output logic       UPDATE,
    output logic       ERR
);

    localparam int               IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
`ifdef SEG_SCAN_MOD60_CHECK_EN
    localparam logic MOD60_EN = 1'b1;
`else
    localparam logic MOD60_EN = 1'b0;
`endif

    logic             accept_s;
    logic [3:0]       an_s;
    logic [6:0]       disp_s;
    logic [4:0]       bcd_s;
    logic             is_tens_s;
    logic             illegal_s;

    logic [3:0]        ones_q, ones_d, tens_q, tens_d;
    logic [3:0]        sh_ones_q, sh_ones_d, sh_tens_q, sh_tens_d;
    logic              have_ones_q, have_ones_d, have_tens_q, have_tens_d;
    logic              valid_q, valid_d, update_q, update_d, err_q, err_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    seg_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .CLK      (CLK),
        .RST      (RST),
        .an_i     (AN),
        .disp_i   (DISP),
        .accept_o (accept_s),
        .an_o     (an_s),
        .disp_o   (disp_s)
    );

    // Decode, frame assembly and scan-stall detection.
    always_comb begin
        bcd_s       = seg_to_bcd(disp_s);
        is_tens_s   = (an_s == AN_TENS);
        illegal_s   = bcd_s[4] || (MOD60_EN && is_tens_s && (bcd_s[3:0] > 4'd5));
        ones_d      = ones_q;
        tens_d      = tens_q;
        sh_ones_d   = sh_ones_q;
        sh_tens_d   = sh_tens_q;
        have_ones_d = have_ones_q;
        have_tens_d = have_tens_q;
        valid_d     = valid_q;
        update_d    = 1'b0;
        err_d       = 1'b0;
        idle_d      = idle_q;
        if (accept_s) begin
            idle_d = {IDLE_W{1'b0}};
            if (illegal_s) begin
                err_d = 1'b1;
                if (is_tens_s) begin
                    have_tens_d = 1'b0;
                end else begin
                    have_ones_d = 1'b0;
                end
            end else if (is_tens_s) begin
                sh_tens_d   = bcd_s[3:0];
                have_tens_d = 1'b1;
            end else begin
                sh_ones_d   = bcd_s[3:0];
                have_ones_d = 1'b1;
            end
            // The completing digit loads the outputs directly instead of waiting a cycle on the flags.
            if (have_ones_d && have_tens_d) begin
                update_d    = !valid_q || ({sh_tens_d, sh_ones_d} != {tens_q, ones_q});
                ones_d      = sh_ones_d;
                tens_d      = sh_tens_d;
                valid_d     = 1'b1;
                have_ones_d = 1'b0;
                have_tens_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end else begin
            if (idle_q != IDLE_MAX) begin
                idle_d = idle_q + 1'b1;
            end else begin
                idle_d = idle_q;
            end
            if (idle_d == IDLE_MAX) begin
                valid_d     = 1'b0;
                have_ones_d = 1'b0;
                have_tens_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end
    end

    // Output, shadow and idle-counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            sh_ones_q   <= 4'd0;
            sh_tens_q   <= 4'd0;
            have_ones_q <= 1'b0;
            have_tens_q <= 1'b0;
            valid_q     <= 1'b0;
            update_q    <= 1'b0;
            err_q       <= 1'b0;
            idle_q      <= {IDLE_W{1'b0}};
        end else begin
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            sh_ones_q   <= sh_ones_d;
            sh_tens_q   <= sh_tens_d;
            have_ones_q <= have_ones_d;
            have_tens_q <= have_tens_d;
            valid_q     <= valid_d;
            update_q    <= update_d;
            err_q       <= err_d;
            idle_q      <= idle_d;
        end
    end

    assign ONES   = ones_q;
    assign TENS   = tens_q;
    assign VALID  = valid_q;
    assign UPDATE = update_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with a cycle-level behavioural model and literal spot checks.
module tb_seg_scan_decoder;

    localparam int S  = 4;
    localparam int TO = 64;
`ifdef SEG_SCAN_MOD60_CHECK_EN
    localparam bit MOD60 = 1'b1;
`else
    localparam bit MOD60 = 1'b0;
`endif

    localparam logic [6:0] P1  = 7'b1111001;
    localparam logic [6:0] P2  = 7'b0100100;
    localparam logic [6:0] P3  = 7'b0110000;
    localparam logic [6:0] P4  = 7'b0011001;
    localparam logic [6:0] P6  = 7'b0000010;
    localparam logic [6:0] P9  = 7'b0010000;
    localparam logic [6:0] PBL = 7'b1111111;
    localparam logic [3:0] A_O = 4'b1110;
    localparam logic [3:0] A_T = 4'b1101;
    localparam logic [3:0] A_N = 4'b1111;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] AN;
    logic [6:0] DISP;
    logic [3:0] ONES, TENS;
    logic       VALID, UPDATE, ERR;

    seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .AN(AN), .DISP(DISP),
        .ONES(ONES), .TENS(TENS), .VALID(VALID), .UPDATE(UPDATE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int upd_cnt = 0;
    int err_cnt = 0;
    int base_u, base_e;

    // Model state: digits and flags from the rules, timing in edge numbers.
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int         cyc = 0, run_n = 0, last_proc = 0;
    bit         seen = 0, pend = 0;
    logic [10:0] prev_in;
    logic [3:0] pend_an;
    logic [6:0] pend_disp;
    int         s_o, s_t;
    bit         h_o, h_t;
    int         m_ones, m_tens;
    bit         m_valid, m_upd, m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  d;
        bit  found, legal, is_t;
        cyc++;
        if (RST) begin
            m_ones = 0; m_tens = 0; m_valid = 0; m_upd = 0; m_err = 0;
            h_o = 0; h_t = 0; s_o = 0; s_t = 0;
            pend = 0; seen = 0; run_n = 0; last_proc = cyc;
        end else begin
            m_upd = 0;
            m_err = 0;
            if (pend) begin
                last_proc = cyc;
                found = 0;
                d = 0;
                for (int k = 0; k < 10; k++) begin
                    if (seg_tab[k] == pend_disp) begin
                        found = 1;
                        d = k;
                    end
                end
                is_t  = (pend_an == A_T);
                legal = found && !(MOD60 && is_t && d >= 6);
                if (!legal) begin
                    m_err = 1;
                    if (is_t) h_t = 0; else h_o = 0;
                end else begin
                    if (is_t) begin s_t = d; h_t = 1; end
                    else begin s_o = d; h_o = 1; end
                    if (h_t && h_o) begin
                        m_upd   = !m_valid || s_t != m_tens || s_o != m_ones;
                        m_tens  = s_t;
                        m_ones  = s_o;
                        m_valid = 1;
                        h_t = 0;
                        h_o = 0;
                    end
                end
            end else if (cyc - last_proc >= TO) begin
                m_valid = 0;
                h_t = 0;
                h_o = 0;
            end
            pend = 0;
            if (seen && {AN, DISP} == prev_in) run_n++;
            else run_n = 1;
            prev_in = {AN, DISP};
            seen = 1;
            if (run_n == S + 1 && (AN == A_O || AN == A_T)) begin
                pend      = 1;
                pend_an   = AN;
                pend_disp = DISP;
            end
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] disp, input int n);
        AN   = an;
        DISP = disp;
        repeat (n) @(negedge CLK);
    endtask

    task automatic scan(input logic [6:0] t, input logic [6:0] o, input int reps);
        for (int r = 0; r < reps; r++) begin
            hold(A_T, t, 10);
            hold(A_O, o, 10);
        end
    endtask

    task automatic mark();
        base_u = upd_cnt;
        base_e = err_cnt;
    endtask

    initial begin
        RST  = 1'b1;
        AN   = A_N;
        DISP = PBL;
        fork
            forever begin
                @(posedge CLK);
                model_step();
                #1;
                chk("cycle", {28'd0, ONES, TENS, VALID, UPDATE, ERR},
                    {m_ones[3:0], m_tens[3:0], m_valid, m_upd, m_err});
                if (UPDATE) upd_cnt++;
                if (ERR) err_cnt++;
            end
        join_none

        repeat (3) @(negedge CLK);
        chk("reset_outs", {28'd0, ONES, TENS, VALID, UPDATE, ERR}, 0);
        RST = 1'b0;

        mark();
        scan(P3, P9, 1);
        chk("first_tens", TENS, 3);
        chk("first_ones", ONES, 9);
        chk("first_valid", VALID, 1);
        chk("first_upd", upd_cnt - base_u, 1);
        chk("first_err", err_cnt - base_e, 0);

        mark();
        scan(P3, P9, 5);
        chk("repeat_upd", upd_cnt - base_u, 0);

        mark();
        scan(P3, P1, 1);
        chk("change_ones", ONES, 1);
        chk("change_upd", upd_cnt - base_u, 1);

        mark();
        for (int i = 0; i < 4; i++) begin
            hold(A_O, P2, 3);
            hold(A_O, P3, 3);
        end
        chk("toggle_upd", upd_cnt - base_u, 0);
        chk("toggle_err", err_cnt - base_e, 0);
        chk("toggle_ones", ONES, 1);

        mark();
        hold(A_O, PBL, 8);
        chk("illegal_err", err_cnt - base_e, 1);
        chk("illegal_upd", upd_cnt - base_u, 0);

        hold(A_N, PBL, 70);
        chk("stall_valid", VALID, 0);
        chk("stall_ones", ONES, 1);
        chk("stall_tens", TENS, 3);

        mark();
        scan(P3, P1, 1);
        chk("resume_valid", VALID, 1);
        chk("resume_upd", upd_cnt - base_u, 1);

        mark();
        scan(P6, P9, 1);
        chk("tens6_err", err_cnt - base_e, MOD60 ? 1 : 0);
        chk("tens6_upd", upd_cnt - base_u, MOD60 ? 0 : 1);
        chk("tens6_tens", TENS, MOD60 ? 3 : 6);

        hold(A_N, PBL, 70);
        hold(A_T, P4, 10);
        RST = 1'b1;
        @(negedge CLK);
        chk("midframe_rst", {28'd0, ONES, TENS, VALID, UPDATE, ERR}, 0);
        RST = 1'b0;

        mark();
        scan(P3, P9, 1);
        chk("post_rst_upd", upd_cnt - base_u, 1);
        chk("post_rst_pair", {TENS, ONES}, 8'h39);

        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
